ps2_keycode_rx: RTL
===================

Name: ps2_keycode_rx

Overview:
- Keyboard-side producer of the 8-bit `keycode` bus consumed by the FireBoy/IceGirl player controllers.
- Receives PS/2 scan-code set 2 frames, tracks break (F0) and extended (E0) prefixes, and translates game keys to USB-HID codes: A=0x04, D=0x07, W=0x1A, etc.
- Holds the code while the key is pressed and drives 0x00 on its release.
- Sits between the board PS/2 pins and the player controllers, in the `Clk` domain.

Parameters:
- TIMEOUT_CYCLES, 50000: `Clk` cycles with no PS/2 falling edge mid-frame before the partial frame is aborted (1 ms at 50 MHz).

Ports:
- Clk  input  1  system clock
- Reset_n  input  1  asynchronous active-low reset
- PS2_CLK  input  1  raw keyboard clock, asynchronous
- PS2_DATA  input  1  raw keyboard data, asynchronous
- keycode  output  8  HID code of the currently held game key; 0x00 = none
- keycode_update  output  1  one-cycle pulse when `keycode` changes value
- frame_error  output  1  one-cycle pulse on a discarded frame

Behaviour:
- Reset (Reset_n=0, async): keycode=0x00, keycode_update=0, frame_error=0; FSM=IDLE; break/ext flags cleared; synchronizers =1; timeout counter=0.
- Sync: PS2_CLK and PS2_DATA each pass through 2 flip-flops. A falling edge is synced clock previous=1, current=0. Data is sampled in the same cycle as the edge.
- Frame FSM (advances only on a falling edge):
  - IDLE: data=0 -> DATA, bit count=0. data=1 -> stay in IDLE (glitch, no error).
  - DATA: shift in LSB first; after 8 bits -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: data=1 and parity ok -> byte_valid pulse next cycle. Otherwise frame_error pulse. Both cases -> IDLE.
- Timeout: counter clears on every falling edge and in IDLE. In DATA/PARITY/STOP, counter == TIMEOUT_CYCLES-1 -> IDLE, frame_error pulse, break/ext flags cleared.
- Byte decode (on byte_valid):
  - 0xE0 -> ext=1.
  - 0xF0 -> brk=1.
  - Any other byte: look up {ext, byte}, act as below, then clear ext and brk.
- Translation table (set-2 -> HID):
  - 1C->04 (A), 23->07 (D), 1D->1A (W), 1B->16 (S)
  - 29->2C (Space), 5A->28 (Enter)
  - E0 6B->50 (Left), E0 74->4F (Right), E0 75->52 (Up), E0 72->51 (Down)
  - Unlisted codes are ignored and leave `keycode` unchanged.
- Make (brk=0), mapped code:
  - code != keycode -> keycode=code, keycode_update=1.
  - Typematic repeat of the held key -> no change, no pulse.
- Break (brk=1), mapped code:
  - code == keycode -> keycode=0x00, keycode_update=1.
  - Release of a non-held key -> no change.
- Latency: keycode and keycode_update register 1 cycle after byte_valid, i.e. 2 Clk cycles after the stop-bit falling-edge sample cycle.
- frame_error and keycode_update can never coincide, since an errored frame produces no byte.
- Reset mid-frame: everything returns to reset values. Any following bits before the next start bit are treated as IDLE glitches or a new frame.
- No transmit path: PS2_CLK and PS2_DATA are input-only, and the keyboard is never inhibited.

Optional Feature:
- PS2_PARITY_CHECK_EN defined: parity must be odd (8 data bits + parity bit). A mismatch discards the byte and pulses frame_error.
- Not defined: the parity bit is captured and ignored.
- A stop-bit error always discards the byte regardless of the macro.

Test Plan:
- Send 0x1C (A make), valid frame at 10 kHz PS/2 clock -> keycode=0x04; one keycode_update pulse 2 cycles after stop sample.
- Send 0x1C then F0 1C -> keycode 0x04 then 0x00; exactly two update pulses.
- Send E0 74, then 1C, then F0 1C -> keycode 0x4F, then 0x04, then 0x00. Then E0 F0 74 -> keycode stays 0x00, no pulse.
- Send 0x1D three times (typematic), then 0x55 (unmapped) -> keycode=0x1A, single pulse only.
- With PS2_PARITY_CHECK_EN: send 0x23 with even parity -> frame_error pulse, keycode unchanged. Without the macro: same frame -> keycode=0x07.
- Stop after 4 data bits; hold PS2_CLK high for TIMEOUT_CYCLES -> frame_error pulse, FSM back to IDLE. Next valid 0x23 -> keycode=0x07.
- Assert Reset_n=0 mid-frame while keycode=0x04 -> keycode=0x00 immediately (async).

Source files
------------

// File: rtl/ps2_keycode_rx.sv
// PS/2 scan-code set 2 receiver for the player controllers.
// Frames arriving on the raw PS2_CLK/PS2_DATA pins are synchronized into the
// Clk domain and deserialized. Break (F0) and extended (E0) prefixes are
// tracked, and game keys are translated to USB-HID codes on `keycode`.
// The held code stays on `keycode` until its break arrives.
// Optional build macro: PS2_PARITY_CHECK_EN. When it is defined, frames
// without odd parity are discarded. Otherwise the parity bit is skipped.
//
// Handshake: there is no back-pressure. keycode_update is a one-cycle pulse
// that is high in the cycle where keycode first shows its new value.
// frame_error is a one-cycle pulse for each discarded frame. The two pulses
// never occur in the same cycle.
module ps2_keycode_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] keycode,
  output logic       keycode_update,
  output logic       frame_error
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  // Synchronizer and edge-detect registers
  logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_prev_q;
  logic ps2_data_s1_q, ps2_data_s2_q;

  // Frame deserializer registers
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_q, byte_d;
  logic          frame_err_q, frame_err_d;
  logic          timeout_abort;
  logic          par_ok;

  // Decoder registers
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [7:0] keycode_q, keycode_d;
  logic       keycode_upd_q, keycode_upd_d;
  logic [7:0] map_code;
  logic       map_hit;

  logic fall;
  logic data_bit;

  assign fall     = ps2_clk_prev_q & ~ps2_clk_s2_q;
  assign data_bit = ps2_data_s2_q;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q, parity_d;
  // The 8 data bits plus the parity bit must hold an odd number of ones.
  assign par_ok = ^{shift_q, parity_q};
`else
  assign par_ok = 1'b1;
`endif

  // Two-flop synchronizers. One extra clock flop is used for falling-edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ps2_clk_s1_q   <= 1'b1;
      ps2_clk_s2_q   <= 1'b1;
      ps2_clk_prev_q <= 1'b1;
      ps2_data_s1_q  <= 1'b1;
      ps2_data_s2_q  <= 1'b1;
    end else begin
      ps2_clk_s1_q   <= PS2_CLK;
      ps2_clk_s2_q   <= ps2_clk_s1_q;
      ps2_clk_prev_q <= ps2_clk_s2_q;
      ps2_data_s1_q  <= PS2_DATA;
      ps2_data_s2_q  <= ps2_data_s1_q;
    end
  end

  // Frame FSM state and deserializer registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      tmo_cnt_q    <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'h00;
      frame_err_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tmo_cnt_q    <= tmo_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      frame_err_q  <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // Frame FSM next state. It advances only on a synchronized PS2_CLK falling edge.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    byte_valid_d  = 1'b0;
    byte_d        = byte_q;
    frame_err_d   = 1'b0;
    timeout_abort = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_d      = parity_q;
`endif
    if ((state_q == ST_IDLE) || fall) tmo_cnt_d = '0;
    else                              tmo_cnt_d = tmo_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        // A falling edge with data high is a glitch. It is ignored without an error.
        if (fall && !data_bit) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          parity_d = data_bit;
`endif
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          if (data_bit && par_ok) begin
            byte_valid_d = 1'b1;
            byte_d       = shift_q;
          end else begin
            frame_err_d  = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort the partial frame when the keyboard stops clocking in the middle of it.
    if ((state_q != ST_IDLE) && !fall && (tmo_cnt_q == TMO_LAST)) begin
      state_d       = ST_IDLE;
      frame_err_d   = 1'b1;
      timeout_abort = 1'b1;
      tmo_cnt_d     = '0;
    end
  end

  // Translation of set-2 scan codes (with the extended prefix) into HID codes
  always_comb begin
    map_hit  = 1'b1;
    map_code = 8'h00;
    case ({ext_q, byte_q})
      9'h01C:  map_code = 8'h04;
      9'h023:  map_code = 8'h07;
      9'h01D:  map_code = 8'h1A;
      9'h01B:  map_code = 8'h16;
      9'h029:  map_code = 8'h2C;
      9'h05A:  map_code = 8'h28;
      9'h16B:  map_code = 8'h50;
      9'h174:  map_code = 8'h4F;
      9'h175:  map_code = 8'h52;
      9'h172:  map_code = 8'h51;
      default: map_hit  = 1'b0;
    endcase
  end

  // Prefix tracking and the make/break update of the held keycode
  always_comb begin
    ext_d         = ext_q;
    brk_d         = brk_q;
    keycode_d     = keycode_q;
    keycode_upd_d = 1'b0;
    if (byte_valid_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (map_hit) begin
          if (!brk_q) begin
            // A typematic repeat of the held key leaves keycode unchanged and does not pulse.
            if (map_code != keycode_q) begin
              keycode_d     = map_code;
              keycode_upd_d = 1'b1;
            end
          end else if (map_code == keycode_q) begin
            keycode_d     = 8'h00;
            keycode_upd_d = 1'b1;
          end
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    if (timeout_abort) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  // Decoder registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      keycode_q     <= 8'h00;
      keycode_upd_q <= 1'b0;
    end else begin
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      keycode_q     <= keycode_d;
      keycode_upd_q <= keycode_upd_d;
    end
  end

  assign keycode        = keycode_q;
  assign keycode_update = keycode_upd_q;
  assign frame_error    = frame_err_q;

endmodule
